// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor
// Summary : Direct-mapped branch target buffer with saturating direction
//           counters and saturating update/mispredict statistics.
// Rev     : 1.0  initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          lookup_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic                 update_taken,
  input  logic [31:0]          update_target,
  input  logic                 update_mispredict,
  input  logic                 flush_all,
  input  logic                 stat_clear,
  output logic [STAT_BITS-1:0] stat_updates,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int                    c_idx_bits = $clog2(ENTRIES);
  localparam int                    c_tag_bits = 30 - c_idx_bits;
  localparam logic [CTR_BITS-1:0]   c_ctr_one  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0]   c_weak_t   = c_ctr_one << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0]   c_weak_nt  = c_weak_t - c_ctr_one;
  localparam logic [CTR_BITS-1:0]   c_ctr_max  = '1;
  localparam logic [CTR_BITS-1:0]   c_ctr_min  = '0;
  localparam logic [STAT_BITS-1:0]  c_stat_one = STAT_BITS'(1);
  localparam logic [STAT_BITS-1:0]  c_stat_max = '1;

  logic [ENTRIES-1:0]    r_valid;
  logic [c_tag_bits-1:0] r_tag    [ENTRIES];
  logic [31:0]           r_target [ENTRIES];
  logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];
  logic [STAT_BITS-1:0]  r_stat_updates;
  logic [STAT_BITS-1:0]  r_stat_mispredicts;

  logic [c_idx_bits-1:0] w_lk_idx;
  logic [c_tag_bits-1:0] w_lk_tag;
  logic                  w_lk_hit;
  logic                  w_lk_taken;
  logic [c_idx_bits-1:0] w_up_idx;
  logic [c_tag_bits-1:0] w_up_tag;
  logic                  w_up_hit;
  logic [3:0]            w_unused_pc_lsbs;

  // Word-aligned PCs: the two low bits never contribute to index or tag.
  assign w_unused_pc_lsbs = {lookup_pc[1:0], update_pc[1:0]};

  assign w_lk_idx   = lookup_pc[c_idx_bits+1:2];
  assign w_lk_tag   = lookup_pc[31:c_idx_bits+2];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_BITS-1];

  assign pred_hit    = w_lk_hit;
  assign pred_taken  = w_lk_taken;
  assign pred_target = w_lk_taken ? r_target[w_lk_idx] : (lookup_pc + 32'd4);

  assign w_up_idx = update_pc[c_idx_bits+1:2];
  assign w_up_tag = update_pc[31:c_idx_bits+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= c_weak_nt;
      end
    end else if (flush_all) begin
      r_valid <= '0;
    end else if (update_valid) begin
      if (w_up_hit) begin
        if (update_taken) begin
          if (r_ctr[w_up_idx] != c_ctr_max) begin
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + c_ctr_one;
          end
          r_target[w_up_idx] <= update_target;
        end else if (r_ctr[w_up_idx] != c_ctr_min) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - c_ctr_one;
        end
      end else if (update_taken) begin
        // Miss on a taken branch replaces whatever occupied the slot.
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= update_target;
        r_ctr[w_up_idx]    <= c_weak_t;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (stat_clear) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (update_valid) begin
      if (r_stat_updates != c_stat_max) begin
        r_stat_updates <= r_stat_updates + c_stat_one;
      end
      if (update_mispredict && (r_stat_mispredicts != c_stat_max)) begin
        r_stat_mispredicts <= r_stat_mispredicts + c_stat_one;
      end
    end
  end

  assign stat_updates     = r_stat_updates;
  assign stat_mispredicts = r_stat_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_predictor
// Summary : Self-checking bench for branch_predictor against a table model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        flush_all;
  logic        stat_clear;
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  // Reference table: slot = (pc / 4) mod 16, tag = pc / 64.
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_upd;
  int          m_mis;

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .STAT_BITS(16)) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .flush_all(flush_all), .stat_clear(stat_clear),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_upd = 0; m_mis = 0;
  endfunction

  function automatic void model_apply(bit v, logic [31:0] pc, bit tk, logic [31:0] tg,
                                      bit mp, bit fl, bit cl);
    int          s = int'((pc / 4) % 16);
    int unsigned t = pc / 64;
    bit          hit = m_valid[s] && (m_tag[s] == t);
    if (cl) begin
      m_upd = 0; m_mis = 0;
    end else if (v) begin
      if (m_upd < 65535) m_upd++;
      if (mp && m_mis < 65535) m_mis++;
    end
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (v) begin
      if (hit && tk) begin
        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        m_target[s] = tg;
      end else if (hit) begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end else if (tk) begin
        m_valid[s] = 1; m_tag[s] = t; m_target[s] = tg; m_ctr[s] = 2;
      end
    end
  endfunction

  task automatic check_lookup(input string tag, input logic [31:0] pc);
    int          s = int'((pc / 4) % 16);
    bit          hit = m_valid[s] && (m_tag[s] == pc / 64);
    bit          tk  = hit && (m_ctr[s] >= 2);
    logic [31:0] tgt = tk ? m_target[s] : pc + 32'd4;
    lookup_pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({tag, "_target"}, pred_target, tgt);
  endtask

  // One clock: lookup is checked before the edge (pre-update contents),
  // stats and the updated slot are checked just after it.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                     input bit mp, input bit fl, input bit cl, input logic [31:0] lpc);
    update_valid = v; update_pc = pc; update_taken = tk; update_target = tg;
    update_mispredict = mp; flush_all = fl; stat_clear = cl;
    check_lookup("pre", lpc);
    @(posedge clk);
    model_apply(v, pc, tk, tg, mp, fl, cl);
    #1;
    update_valid = 1'b0; flush_all = 1'b0; stat_clear = 1'b0;
    check("stat_updates", {16'd0, stat_updates}, m_upd);
    check("stat_mispredicts", {16'd0, stat_mispredicts}, m_mis);
    check_lookup("post", pc);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p = 32'h0040_0000;
    p[7:6] = 2'($urandom_range(0, 3));
    p[5:2] = 4'($urandom_range(0, 15));
    return p;
  endfunction

  initial begin
    logic [31:0] a, b;
    reset = 1'b0; lookup_pc = '0; update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_mispredict = 1'b0; flush_all = 1'b0; stat_clear = 1'b0;
    model_reset();
    #2;
    check_lookup("rst", 32'h0040_0010);
    check("rst_target_const", pred_target, 32'h0040_0014);
    check("rst_upd", {16'd0, stat_updates}, 32'd0);
    check("rst_mis", {16'd0, stat_mispredicts}, 32'd0);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;

    // Allocate, then walk the counter down and up.
    cyc(1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0, 0, 32'h0040_0010);
    check("alloc_target_const", pred_target, 32'h0040_0040);
    check("alloc_upd_const", {16'd0, stat_updates}, 32'd1);
    cyc(1, 32'h0040_0010, 0, 32'h0, 1, 0, 0, 32'h0040_0010);
    check("walk_nt_target_const", pred_target, 32'h0040_0014);
    cyc(1, 32'h0040_0010, 0, 32'h0, 0, 0, 0, 32'h0040_0010);
    for (int i = 0; i < 4; i++) cyc(1, 32'h0040_0010, 1, 32'h0040_0040, 0, 0, 0, 32'h0040_0010);

    // Alias on slot 4.
    check_lookup("alias_miss", 32'h0040_0050);
    cyc(1, 32'h0040_0050, 0, 32'h0, 0, 0, 0, 32'h0040_0050);
    check_lookup("alias_keep", 32'h0040_0010);
    cyc(1, 32'h0040_0050, 1, 32'h0040_0100, 0, 0, 0, 32'h0040_0010);
    check_lookup("alias_evict", 32'h0040_0010);

    // Flush beats a same-cycle allocate; stats still count it.
    cyc(1, 32'h0040_0020, 1, 32'h0040_0200, 0, 0, 0, 32'h0040_0020);
    cyc(1, 32'h0040_0020, 1, 32'h0040_0300, 0, 1, 0, 32'h0040_0020);
    check_lookup("flush_a", 32'h0040_0050);
    check_lookup("flush_b", 32'h0040_0020);
    check("flush_hit_const", {31'd0, pred_hit}, 32'd0);
    check_lookup("wrap", 32'hFFFF_FFFC);
    check("wrap_const", pred_target, 32'h0000_0000);

    // Randomised traffic, including flushes and stat clears.
    for (int i = 0; i < 3000; i++) begin
      a = rand_pc();
      b = rand_pc();
      cyc(($urandom_range(0, 3) != 0), a, $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0, b);
    end

    // Drive the statistics to saturation.
    cyc(0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 65534; i++) cyc(1, rand_pc(), $urandom_range(0, 1) == 1, 32'h0040_0400, 1, 0, 0, rand_pc());
    check("pre_sat_const", {16'd0, stat_mispredicts}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      cyc(1, rand_pc(), 1, 32'h0040_0800, 1, 0, 0, rand_pc());
      check("mis_sat_const", {16'd0, stat_mispredicts}, 32'h0000_FFFF);
    end
    check("upd_sat_const", {16'd0, stat_updates}, 32'h0000_FFFF);
    cyc(1, 32'h0040_0010, 1, 32'h0040_0040, 1, 0, 1, 32'h0040_0010);
    check("clear_upd_const", {16'd0, stat_updates}, 32'd0);
    check("clear_mis_const", {16'd0, stat_mispredicts}, 32'd0);
    cyc(1, 32'h0040_0010, 1, 32'h0040_0040, 1, 0, 0, 32'h0040_0010);

    // Asynchronous reset in the middle of an update cycle.
    update_valid = 1'b1; update_pc = 32'h0040_0010; update_taken = 1'b1;
    update_target = 32'h0040_0044; update_mispredict = 1'b1;
    lookup_pc = 32'h0040_0010;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_hit", {31'd0, pred_hit}, 32'd0);
    check("async_taken", {31'd0, pred_taken}, 32'd0);
    check("async_target", pred_target, 32'h0040_0014);
    check("async_upd", {16'd0, stat_updates}, 32'd0);
    check("async_mis", {16'd0, stat_mispredicts}, 32'd0);
    @(posedge clk); #3;
    update_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_lookup("after_rst", 32'h0040_0010);
    for (int i = 0; i < 200; i++) cyc(1, rand_pc(), $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
                                      $urandom_range(0, 1) == 1, 0, 0, rand_pc());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
